// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch/redirect path.
package branch_pkg;

    typedef enum logic [1:0] {
        PS_NONE   = 2'd0,
        PS_JAL    = 2'd1,
        PS_JALR   = 2'd2,
        PS_BRANCH = 2'd3
    } pc_sel_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN       = 1'b0,
        TRAP_WAIT = 1'b1
    } redir_state_t;

endpackage

// File: rtl/branch_cond_gen.sv
// Combinational evaluation of the RV32 conditional-branch predicate.
module branch_cond_gen
    import branch_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_taken
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (i_rs1 == i_rs2);
    assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u = (i_rs1 < i_rs2);

    // funct3 010 and 011 are reserved encodings and never branch.
    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = w_eq;
            F3_BNE:  o_taken = !w_eq;
            F3_BLT:  o_taken = w_lt_s;
            F3_BGE:  o_taken = !w_lt_s;
            F3_BLTU: o_taken = w_lt_u;
            F3_BGEU: o_taken = !w_lt_u;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves EX-stage control transfers, owns the fetch PC, drives pipeline
// flushes and requests a trap for misaligned targets.
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PC_STALL,
    input  logic             EX_VALID,
    input  pc_sel_t          EX_PC_SEL,
    input  logic [2:0]       EX_FUNCT3,
    input  logic [31:0]      EX_RS1,
    input  logic [31:0]      EX_RS2,
    input  logic [31:0]      EX_JAL,
    input  logic [31:0]      EX_JALR,
    input  logic [31:0]      EX_BRANCH,
    input  logic [31:0]      MTVEC,
    input  logic             TRAP_ACK,
    output logic [31:0]      PC,
    output logic [31:0]      PC_PLUS4,
    output logic             FLUSH_IF_ID,
    output logic             FLUSH_ID_EX,
    output logic             TRAP_REQ,
    output logic [31:0]      TRAP_TVAL,
    output logic [CNT_W-1:0] BR_RESOLVED,
    output logic [CNT_W-1:0] BR_TAKEN,
    output redir_state_t     DBG_STATE
);

    // TRAP_REQ/TRAP_ACK: REQ is held high from the misaligned take until the
    // first edge that samples ACK high; ACK outside TRAP_WAIT has no effect.

    redir_state_t     r_state;
    logic [31:0]      r_pc;
    logic             r_trap_req;
    logic [31:0]      r_trap_tval;
    logic [CNT_W-1:0] r_resolved;
    logic [CNT_W-1:0] r_taken;

    redir_state_t     w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic             w_req_nxt;
    logic [31:0]      w_tval_nxt;
    logic             w_cond;
    logic             w_take;
    logic             w_misaligned;
    logic             w_resolve;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;

    branch_cond_gen u_cond (
        .i_funct3 (EX_FUNCT3),
        .i_rs1    (EX_RS1),
        .i_rs2    (EX_RS2),
        .o_taken  (w_cond)
    );

    always_comb begin
        w_target = EX_BRANCH;
        case (EX_PC_SEL)
            PS_JAL:  w_target = EX_JAL;
            PS_JALR: w_target = {EX_JALR[31:1], 1'b0};
            default: w_target = EX_BRANCH;
        endcase
    end

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_resolve    = EX_VALID && (r_state == RUN) && (EX_PC_SEL != PS_NONE);
    assign w_take       = w_resolve &&
                          ((EX_PC_SEL == PS_JAL) || (EX_PC_SEL == PS_JALR) ||
                           ((EX_PC_SEL == PS_BRANCH) && w_cond));
    assign w_misaligned = w_take && w_target[1];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_trap_req;
        w_tval_nxt  = r_trap_tval;
        case (r_state)
            RUN: begin
                if (w_take) begin
                    if (w_misaligned) begin
                        w_tval_nxt  = w_target;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = TRAP_WAIT;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (!PC_STALL) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            TRAP_WAIT: begin
                if (TRAP_ACK) begin
                    w_pc_nxt    = MTVEC;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_pc        <= RESET_VEC;
            r_trap_req  <= 1'b0;
            r_trap_tval <= 32'd0;
            r_resolved  <= '0;
            r_taken     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_trap_req  <= w_req_nxt;
            r_trap_tval <= w_tval_nxt;
            if (w_resolve) r_resolved <= r_resolved + CNT_W'(1);
            if (w_take)    r_taken    <= r_taken + CNT_W'(1);
        end
    end

    // Flushes stay up for the whole trap wait so nothing younger retires.
    assign FLUSH_IF_ID = w_take || (r_state == TRAP_WAIT);
    assign FLUSH_ID_EX = w_take || (r_state == TRAP_WAIT);

    assign PC          = r_pc;
    assign PC_PLUS4    = w_pc_plus4;
    assign TRAP_REQ    = r_trap_req;
    assign TRAP_TVAL   = r_trap_tval;
    assign BR_RESOLVED = r_resolved;
    assign BR_TAKEN    = r_taken;
    assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: branch-condition table plus
// hand-written redirect, stall, trap and reset sequences.
module tb_branch_redirect_unit;
    import branch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic         CLK = 1'b0;
    logic         RST, PC_STALL, EX_VALID, TRAP_ACK;
    pc_sel_t      EX_PC_SEL;
    logic [2:0]   EX_FUNCT3;
    logic [31:0]  EX_RS1, EX_RS2, EX_JAL, EX_JALR, EX_BRANCH, MTVEC;
    logic [31:0]  PC, PC_PLUS4, TRAP_TVAL;
    logic         FLUSH_IF_ID, FLUSH_ID_EX, TRAP_REQ;
    logic [31:0]  BR_RESOLVED, BR_TAKEN;
    redir_state_t DBG_STATE;

    branch_redirect_unit #(.RESET_VEC(RV), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .PC_STALL(PC_STALL), .EX_VALID(EX_VALID),
        .EX_PC_SEL(EX_PC_SEL), .EX_FUNCT3(EX_FUNCT3), .EX_RS1(EX_RS1),
        .EX_RS2(EX_RS2), .EX_JAL(EX_JAL), .EX_JALR(EX_JALR),
        .EX_BRANCH(EX_BRANCH), .MTVEC(MTVEC), .TRAP_ACK(TRAP_ACK),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .FLUSH_IF_ID(FLUSH_IF_ID),
        .FLUSH_ID_EX(FLUSH_ID_EX), .TRAP_REQ(TRAP_REQ), .TRAP_TVAL(TRAP_TVAL),
        .BR_RESOLVED(BR_RESOLVED), .BR_TAKEN(BR_TAKEN), .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_pc, exp_res, exp_tak, exp_tval;
    logic        exp_req;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] tgt;
        logic        take;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        PC_STALL = 1'b0; EX_VALID = 1'b0; EX_PC_SEL = PS_NONE; EX_FUNCT3 = 3'b000;
        EX_RS1 = '0; EX_RS2 = '0; EX_JAL = '0; EX_JALR = '0; EX_BRANCH = '0;
        TRAP_ACK = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_flush(input string name, input logic exp);
        #1;
        chk({name, "_flush_if_id"}, 32'(FLUSH_IF_ID), 32'(exp));
        chk({name, "_flush_id_ex"}, 32'(FLUSH_ID_EX), 32'(exp));
    endtask

    task automatic chk_regs(input string name);
        chk({name, "_pc"}, PC, exp_pc);
        chk({name, "_pc_plus4"}, PC_PLUS4, exp_pc + 32'd4);
        chk({name, "_resolved"}, BR_RESOLVED, exp_res);
        chk({name, "_taken"}, BR_TAKEN, exp_tak);
        chk({name, "_trap_req"}, 32'(TRAP_REQ), 32'(exp_req));
        chk({name, "_trap_tval"}, TRAP_TVAL, exp_tval);
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_pc = RV; exp_res = 0; exp_tak = 0; exp_req = 1'b0; exp_tval = 0;
    endtask

    initial begin
        // BLT/BLTU pair with the same operands leads the table.
        tbl[0]  = '{F3_BLT,  32'hFFFF_FFFF, 32'd1,        32'h0000_0200, 1'b1};
        tbl[1]  = '{F3_BLTU, 32'hFFFF_FFFF, 32'd1,        32'h0000_0A00, 1'b0};
        tbl[2]  = '{F3_BEQ,  32'd5,         32'd5,        32'h0000_1000, 1'b1};
        tbl[3]  = '{F3_BEQ,  32'd5,         32'd6,        32'h0000_1010, 1'b0};
        tbl[4]  = '{F3_BNE,  32'd5,         32'd6,        32'h0000_1020, 1'b1};
        tbl[5]  = '{F3_BNE,  32'd7,         32'd7,        32'h0000_1030, 1'b0};
        tbl[6]  = '{F3_BGE,  32'd1,         32'hFFFF_FFFF, 32'h0000_1040, 1'b1};
        tbl[7]  = '{F3_BGE,  32'd3,         32'd3,        32'h0000_1050, 1'b1};
        tbl[8]  = '{F3_BGEU, 32'd1,         32'hFFFF_FFFF, 32'h0000_1060, 1'b0};
        tbl[9]  = '{F3_BLTU, 32'd1,         32'hFFFF_FFFF, 32'h0000_1070, 1'b1};
        tbl[10] = '{F3_BLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_1080, 1'b1};
        tbl[11] = '{3'b010,  32'd5,         32'd5,        32'h0000_1090, 1'b0};
        tbl[12] = '{3'b011,  32'd1,         32'd2,        32'h0000_10A0, 1'b0};
        tbl[13] = '{F3_BGEU, 32'd3,         32'd3,        32'h0000_10B0, 1'b1};

        MTVEC = 32'h0000_0080;

        // Reset, then three idle cycles.
        do_reset();
        chk_flush("reset", 1'b0);
        chk_regs("reset");
        chk("reset_state", 32'(DBG_STATE), 32'(RUN));
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            chk_regs("idle");
        end

        // Stall without redirect holds PC; ACK in RUN is ignored.
        PC_STALL = 1'b1;
        TRAP_ACK = 1'b1;
        tick();
        chk_regs("stall_hold");
        idle();

        // Conditional-branch table.
        for (int i = 0; i < 14; i++) begin
            EX_VALID  = 1'b1;
            EX_PC_SEL = PS_BRANCH;
            EX_FUNCT3 = tbl[i].f3;
            EX_RS1    = tbl[i].rs1;
            EX_RS2    = tbl[i].rs2;
            EX_BRANCH = tbl[i].tgt;
            chk_flush($sformatf("br%0d", i), tbl[i].take);
            tick();
            exp_res = exp_res + 1;
            if (tbl[i].take) begin
                exp_pc  = tbl[i].tgt;
                exp_tak = exp_tak + 1;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
            chk_regs($sformatf("br%0d", i));
            idle();
        end

        // JALR with bit 0 set, concurrent stall: redirect wins.
        EX_VALID = 1'b1; EX_PC_SEL = PS_JALR; EX_JALR = 32'h0000_0301; PC_STALL = 1'b1;
        chk_flush("jalr", 1'b1);
        tick();
        exp_pc = 32'h300; exp_res = exp_res + 1; exp_tak = exp_tak + 1;
        chk_regs("jalr");
        idle();

        // Misaligned JAL enters the trap wait with PC frozen.
        EX_VALID = 1'b1; EX_PC_SEL = PS_JAL; EX_JAL = 32'h0000_0402;
        chk_flush("jal_mis", 1'b1);
        tick();
        exp_res = exp_res + 1; exp_tak = exp_tak + 1; exp_req = 1'b1; exp_tval = 32'h402;
        chk_regs("jal_mis");
        chk("jal_mis_state", 32'(DBG_STATE), 32'(TRAP_WAIT));
        EX_JAL = 32'h0000_0500;
        for (int i = 0; i < 3; i++) begin
            chk_flush("trap_wait", 1'b1);
            tick();
            chk_regs("trap_wait");
        end
        idle();
        TRAP_ACK = 1'b1;
        chk_flush("trap_ack", 1'b1);
        tick();
        exp_pc = 32'h80; exp_req = 1'b0;
        chk_regs("trap_ack");
        idle();
        chk_flush("after_ack", 1'b0);

        // Reset during trap wait, with no ACK.
        EX_VALID = 1'b1; EX_PC_SEL = PS_JALR; EX_JALR = 32'h0000_0603;
        tick();
        idle();
        chk("pre_rst_req", 32'(TRAP_REQ), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_pc = RV; exp_res = 0; exp_tak = 0; exp_req = 1'b0; exp_tval = 0;
        chk_regs("rst_trap");
        chk_flush("rst_trap", 1'b0);

        // Wrap from FFFF_FFFC, reserved funct3, and a bubble carrying PS_JAL.
        EX_VALID = 1'b1; EX_PC_SEL = PS_JAL; EX_JAL = 32'hFFFF_FFFC;
        tick();
        exp_pc = 32'hFFFF_FFFC; exp_res = 1; exp_tak = 1;
        chk_regs("to_top");
        idle();
        EX_VALID = 1'b1; EX_PC_SEL = PS_BRANCH; EX_FUNCT3 = 3'b010;
        EX_RS1 = 32'd9; EX_RS2 = 32'd9; EX_BRANCH = 32'h0000_0700;
        chk_flush("f3_010", 1'b0);
        tick();
        exp_pc = 32'h0; exp_res = 2;
        chk_regs("f3_010");
        idle();
        EX_PC_SEL = PS_JAL; EX_JAL = 32'h0000_0800;
        chk_flush("bubble_jal", 1'b0);
        tick();
        exp_pc = 32'h4;
        chk_regs("bubble_jal");
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
